// File: rtl/acia_rx_feeder.sv
// Byte FIFO feeding an 8N1 serialiser that drives the ACIA rx line at one of two bit rates.
// Optional ACIA_RX_FEEDER_GAP_EN adds one extra idle bit time after every stop bit.
module acia_rx_feeder #(
  parameter int DEPTH_LOG2    = 4,
  parameter int BIT_CLKS_SLOW = 4096,
  parameter int BIT_CLKS_FAST = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rate_sel,
  input  logic [7:0]            din,
  input  logic                  din_strobe,
  input  logic                  ovf_clr,
  output logic                  tx,
  output logic                  busy,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int BIT_MAX  = (BIT_CLKS_SLOW > BIT_CLKS_FAST) ? BIT_CLKS_SLOW : BIT_CLKS_FAST;
  localparam int TW       = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam logic [TW-1:0] LOAD_SLOW = TW'(BIT_CLKS_SLOW - 1);
  localparam logic [TW-1:0] LOAD_FAST = TW'(BIT_CLKS_FAST - 1);

`ifdef ACIA_RX_FEEDER_GAP_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  wr_en;
  logic                  rd_en;
  logic [7:0]            shift;
  logic [2:0]            bit_idx;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         reload;
  logic                  rate_q;

  // full is a register, so a strobe in the same cycle as a pop from a full FIFO is still dropped.
  assign wr_en      = din_strobe & ~full;
  assign rd_en      = (state == IDLE) & ~empty;
  assign level_next = level + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(rd_en);
  assign reload     = rate_q ? LOAD_FAST : LOAD_SLOW;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_en) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == (DEPTH_LOG2 + 1)'(DEPTH));
      // A dropped write wins over a clear in the same cycle.
      if (din_strobe && full) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      shift   <= '0;
      bit_idx <= '0;
      timer   <= '0;
      rate_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift  <= mem[rd_ptr];
            rate_q <= rate_sel;
            timer  <= rate_sel ? LOAD_FAST : LOAD_SLOW;
            tx     <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (timer == '0) begin
            timer   <= reload;
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= reload;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) begin
`ifdef ACIA_RX_FEEDER_GAP_EN
            timer <= reload;
            state <= GAP;
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end else begin
            timer <= timer - TW'(1);
          end
        end
`ifdef ACIA_RX_FEEDER_GAP_EN
        GAP: begin
          if (timer == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
`endif
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acia_rx_feeder.sv
// Bench for acia_rx_feeder: frame-level reference model compared every cycle, plus directed literal checks.
module tb_acia_rx_feeder;

  localparam int DL   = 4;
  localparam int DEP  = 1 << DL;
  localparam int SLOW = 64;
  localparam int FAST = 16;
`ifdef ACIA_RX_FEEDER_GAP_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int GAPX = NB - 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rate_sel = 1'b0;
  logic [7:0]    din = '0;
  logic          din_strobe = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx, busy, empty, full, overflow;
  logic [DL:0]   level;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  acia_rx_feeder #(.DEPTH_LOG2(DL), .BIT_CLKS_SLOW(SLOW), .BIT_CLKS_FAST(FAST)) dut (
    .clk(clk), .reset(reset), .rate_sel(rate_sel), .din(din), .din_strobe(din_strobe),
    .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .empty(empty), .full(full),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue of bytes plus the one frame on the line, described by start cycle and bit length.
  logic [7:0] exp_q[$];
  int         t = 0;
  bit         fr_valid = 1'b0;
  int         fr_start = 0;
  int         fr_bc = SLOW;
  logic [7:0] fr_byte = '0;
  bit         m_ovf = 1'b0;

  function automatic bit in_frame(input int c);
    return fr_valid && c >= fr_start && c < fr_start + NB * fr_bc;
  endfunction

  function automatic logic exp_tx(input int c);
    int k;
    if (!in_frame(c)) return 1'b1;
    k = (c - fr_start) / fr_bc;
    if (k == 0) return 1'b0;
    if (k <= 8) return fr_byte[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit do_pop, do_wr, drop;
    if (reset) begin
      exp_q.delete();
      fr_valid = 1'b0;
      m_ovf    = 1'b0;
      t = t + 1;
    end else begin
      do_pop = !in_frame(t) && exp_q.size() != 0;
      drop   = din_strobe && exp_q.size() == DEP;
      do_wr  = din_strobe && exp_q.size() != DEP;
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      t = t + 1;
      if (do_pop) begin
        fr_byte  = exp_q.pop_front();
        fr_bc    = rate_sel ? FAST : SLOW;
        fr_start = t;
        fr_valid = 1'b1;
      end
      if (do_wr) exp_q.push_back(din);
    end
  end

  always @(negedge clk) begin
    logic [DL+5:0] act, req;
    if (chk_en) begin
      act = {tx, busy, empty, full, overflow, level};
      req = {exp_tx(t), in_frame(t), exp_q.size() == 0, exp_q.size() == DEP, m_ovf, (DL+1)'(exp_q.size())};
      n_checks++;
      if (act !== req) begin
        n_errors++;
        $display("FAIL model t=%0d {tx,busy,empty,full,ovf,level} got=%b want=%b", t, act, req);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && empty === 1'b1) && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20000) check("wait_idle_timeout", n, 0);
  endtask

  task automatic wait_tx(input logic lvl);
    int n = 0;
    while (tx !== lvl && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) check("wait_tx_timeout", n, 0);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic push_burst(input int cnt, input logic rate);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      rate_sel = rate; din = 8'($urandom_range(0, 255)); din_strobe = 1'b1;
    end
    @(posedge clk); #1;
    din_strobe = 1'b0;
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b, input logic rate);
    @(posedge clk); #1; rate_sel = rate; din = a; din_strobe = 1'b1;
    @(posedge clk); #1; din = b;
    @(posedge clk); #1; din_strobe = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int k, n;
    logic line[$];
    logic [7:0] dec;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_empty", empty, 1);
    check("reset_level", level, 0);

    // 0xA5 at fast rate: start bit two cycles after the strobe cycle.
    @(posedge clk); #1; rate_sel = 1'b1; din = 8'hA5; din_strobe = 1'b1;
    @(posedge clk); #1; din_strobe = 1'b0;
    k = 1;
    @(negedge clk);
    while (tx !== 1'b0 && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("a5_fall_latency", k, 2);
    check("a5_busy_rise", busy, 1);
    line.delete();
    while (busy === 1'b1 && line.size() < 5000) begin
      line.push_back(tx);
      @(negedge clk);
    end
    check("a5_busy_len", line.size(), NB * FAST);
    if (line.size() >= 10 * FAST) begin
      for (int i = 0; i < 8; i++) dec[i] = line[(i + 1) * FAST + FAST / 2];
      check("a5_start_bit", line[FAST / 2], 0);
      check("a5_decoded", dec, 8'hA5);
      check("a5_stop_bit", line[9 * FAST + FAST / 2], 1);
    end

    // 0x00 then 0xFF back-to-back at slow rate.
    wait_idle();
    push2(8'h00, 8'hFF, 1'b0);
    wait_tx(1'b0);
    run_len(1'b0, n); check("b2b_low_run", n, 9 * SLOW);
    run_len(1'b1, n); check("b2b_sep_high", n, SLOW + 1 + GAPX * SLOW);
    run_len(1'b0, n); check("b2b_ff_start", n, SLOW);

    // 17 consecutive strobes while idle, then an 18th into a full FIFO.
    wait_idle();
    push_burst(17, 1'b1);
    @(negedge clk);
    check("burst_level", level, 16);
    check("burst_full", full, 1);
    check("burst_ovf_clear", overflow, 0);
    @(posedge clk); #1; din = 8'h77; din_strobe = 1'b1;
    @(posedge clk); #1; din_strobe = 1'b0;
    @(negedge clk);
    check("drop_ovf_set", overflow, 1);
    check("drop_level", level, 16);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);

    // rate_sel changes during frame 1 only affect frame 2.
    wait_idle();
    push2(8'h01, 8'h01, 1'b0);
    wait_tx(1'b0);
    rate_sel = 1'b1;
    run_len(1'b0, n); check("rate_f1_start", n, SLOW);
    run_len(1'b1, n); check("rate_f1_bit0", n, SLOW);
    run_len(1'b0, n); check("rate_f1_zeros", n, 7 * SLOW);
    run_len(1'b1, n); check("rate_sep", n, SLOW + 1 + GAPX * SLOW);
    run_len(1'b0, n); check("rate_f2_start", n, FAST);
    run_len(1'b1, n); check("rate_f2_bit0", n, FAST);
    run_len(1'b0, n); check("rate_f2_zeros", n, 7 * FAST);

    // Reset in data bit 3 aborts the frame and flushes the FIFO.
    wait_idle();
    push2(8'h00, 8'h00, 1'b1);
    wait_tx(1'b0);
    repeat (4 * FAST + FAST / 2) @(negedge clk);
    check("abort_pre_tx", tx, 0);
    check("abort_pre_level", level, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_level", level, 0);
    check("abort_empty", empty, 1);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    k = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) k++;
    end
    check("abort_quiet", k, 0);

    // Randomized traffic with bursts, rate flips, clears and rare resets.
    for (int c = 0; c < 30000; c++) begin
      @(posedge clk); #1;
      din        = 8'($urandom_range(0, 255));
      din_strobe = ($urandom_range(0, 99) < ((c / 3000) % 2 == 0 ? 2 : 30));
      ovf_clr    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) rate_sel = ~rate_sel;
      reset      = ($urandom_range(0, 7999) == 0);
    end
    @(posedge clk); #1;
    din_strobe = 1'b0; ovf_clr = 1'b0; reset = 1'b0;
    wait_idle();
    check("final_level", level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
